// File: rtl/cache_drv_pkg.sv
// Shared types for the cache-memory request driver: request payload, FSM states, default widths.
package cache_drv_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } drv_state_t;

endpackage

// File: rtl/cache_req_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit so full/empty come from an MSB compare.
module cache_req_fifo
  import cache_drv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = req_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  T     wdata,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign rdata = mem[rd_ptr[IDX_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage is not reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[IDX_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/cache_mem_driver.sv
// Cache-memory port initiator: queues requests, issues single-cycle rd_en/wr_en strobes, returns reads.
// Optional CACHE_DRV_STATS_EN adds saturating 16-bit rd_cnt/wr_cnt strobe counters.
module cache_mem_driver
  import cache_drv_pkg::*;
#(
  parameter int unsigned ADDR_W  = cache_drv_pkg::ADDR_W,
  parameter int unsigned DATA_W  = cache_drv_pkg::DATA_W,
  parameter int unsigned Q_DEPTH = 4,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rd_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  output logic              busy
`ifdef CACHE_DRV_STATS_EN
  ,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt
`endif
);

  localparam int unsigned CNT_W = 2;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } drv_req_t;

  drv_state_t       state;
  logic [CNT_W-1:0] lat_cnt;
  drv_req_t         push_req;
  drv_req_t         head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push_c;
  logic             pop_c;

  assign push_req.wr    = req_wr;
  assign push_req.addr  = req_addr;
  assign push_req.wdata = req_wdata;

  assign req_ready = !fifo_full;
  assign push_c    = req_valid && !fifo_full;
  assign busy      = !fifo_empty || (state != ST_IDLE);

  // Pop from IDLE, or chain straight on from a write so queued writes stream one per clock.
  assign pop_c = !fifo_empty && ((state == ST_IDLE) || ((state == ST_ISSUE) && wr_en));

  cache_req_fifo #(
    .DEPTH (Q_DEPTH),
    .T     (drv_req_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .wdata (push_req),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      lat_cnt   <= '0;
      rd_en     <= 1'b0;
      wr_en     <= 1'b0;
      addr      <= '0;
      data_in   <= '0;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_rdata <= '0;
    end else begin
      rd_en <= 1'b0;
      wr_en <= 1'b0;

      // Strobes are registered, so the ISSUE cycle is the one after the pop edge.
      if (pop_c) begin
        rd_en <= !head.wr;
        wr_en <= head.wr;
        addr  <= head.addr;
        if (head.wr)
          data_in <= head.wdata;
      end

      case (state)
        ST_IDLE: begin
          if (!fifo_empty)
            state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (rd_en) begin
            state   <= ST_WAIT;
            lat_cnt <= CNT_W'(RD_LAT);
          end else if (fifo_empty) begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == CNT_W'(1)) begin
            rsp_rdata <= data_out;
            rsp_addr  <= addr;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
          lat_cnt <= lat_cnt - CNT_W'(1);
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CACHE_DRV_STATS_EN
  // Count strobes as they appear on the port; hold at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (rd_en && (rd_cnt != 16'hFFFF))
        rd_cnt <= rd_cnt + 16'd1;
      if (wr_en && (wr_cnt != 16'hFFFF))
        wr_cnt <= wr_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_mem_driver.sv
// Scoreboard bench for cache_mem_driver; three instances cover RD_LAT = 1, 2, 3 on shared stimulus.
module tb_cache_mem_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_wr;
  logic [4:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_ready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic       wr;
    logic [4:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t       strobe_q[$];
  exp_t       rsp_q[$];
  logic [7:0] ref_mem [32];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(int i);
    return 8'(i * 37 + 11);
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned L = g + 1;
    logic       req_ready, rsp_valid, rd_en, wr_en, busy;
    logic [4:0] rsp_addr, addr;
    logic [7:0] rsp_rdata, data_in, data_out;
`ifdef CACHE_DRV_STATS_EN
    logic [15:0] rd_cnt, wr_cnt;
`endif
    logic [7:0] mem [32];
    logic [7:0] pd  [L];
    logic       pv  [L];
    int         last_rd = 0;
    logic       prev_v  = 1'b0;

    // Cache model: read data is valid only in cycle T+L, garbage otherwise.
    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
        for (int i = 0; i < int'(L); i++) pv[i] <= 1'b0;
      end else begin
        if (wr_en) mem[addr] <= data_in;
        pv[0] <= rd_en;
        pd[0] <= mem[addr];
        for (int i = 1; i < int'(L); i++) begin
          pv[i] <= pv[i-1];
          pd[i] <= pd[i-1];
        end
      end
    end
    assign data_out = pv[L-1] ? pd[L-1] : 8'hEE;

    always @(negedge clk) begin
      if (rd_en) last_rd <= cyc;
      prev_v <= rsp_valid;
      if (!rst && rsp_valid && !prev_v)
        check($sformatf("rsp_lat_L%0d", L), 32'(cyc - last_rd), 32'(L + 1));
    end

    cache_mem_driver #(
      .ADDR_W (5),
      .DATA_W (8),
      .Q_DEPTH(4),
      .RD_LAT (L)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_wr   (req_wr),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_addr (rsp_addr),
      .rsp_rdata(rsp_rdata),
      .rd_en    (rd_en),
      .wr_en    (wr_en),
      .addr     (addr),
      .data_in  (data_in),
      .data_out (data_out),
      .busy     (busy)
`ifdef CACHE_DRV_STATS_EN
      ,
      .rd_cnt   (rd_cnt),
      .wr_cnt   (wr_cnt)
`endif
    );
  end

  // Strobe and response scoreboards on the RD_LAT=1 instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (g_dut[0].rd_en || g_dut[0].wr_en) begin
        check("strobe_excl", 32'(g_dut[0].rd_en & g_dut[0].wr_en), 32'd0);
        if (strobe_q.size() == 0) begin
          check("strobe_unexp", 32'd1, 32'd0);
        end else begin
          e = strobe_q.pop_front();
          check("strobe_wr", 32'(g_dut[0].wr_en), 32'(e.wr));
          check("strobe_addr", 32'(g_dut[0].addr), 32'(e.a));
          if (e.wr) check("strobe_data", 32'(g_dut[0].data_in), 32'(e.d));
        end
      end
      if (g_dut[0].rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexp", 32'd1, 32'd0);
        end else begin
          e = rsp_q.pop_front();
          check("rsp_addr", 32'(g_dut[0].rsp_addr), 32'(e.a));
          check("rsp_rdata", 32'(g_dut[0].rsp_rdata), 32'(e.d));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic wr, input logic [4:0] a, input logic [7:0] d);
    int n = 0;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    while (!g_dut[0].req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      check("req_timeout", 32'd0, 32'd1);
    end else begin
      strobe_q.push_back('{wr: wr, a: a, d: d});
      if (wr) ref_mem[a] = d;
      else    rsp_q.push_back('{wr: 1'b0, a: a, d: ref_mem[a]});
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((g_dut[0].busy || g_dut[1].busy || g_dut[2].busy ||
            g_dut[0].rsp_valid || g_dut[1].rsp_valid || g_dut[2].rsp_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("idle_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_rsp0();
    int n = 0;
    while (!g_dut[0].rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int run;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
    repeat (3) @(negedge clk);

    check("rst_req_ready", 32'(g_dut[0].req_ready), 32'd1);
    check("rst_rsp_valid", 32'(g_dut[0].rsp_valid), 32'd0);
    check("rst_rsp_addr",  32'(g_dut[0].rsp_addr),  32'd0);
    check("rst_rsp_rdata", 32'(g_dut[0].rsp_rdata), 32'd0);
    check("rst_rd_en",     32'(g_dut[0].rd_en),     32'd0);
    check("rst_wr_en",     32'(g_dut[0].wr_en),     32'd0);
    check("rst_addr",      32'(g_dut[0].addr),      32'd0);
    check("rst_data_in",   32'(g_dut[0].data_in),   32'd0);
    check("rst_busy",      32'(g_dut[0].busy),      32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Write then read back the same location.
    send(1'b1, 5'd5, 8'hA5);
    send(1'b0, 5'd5, 8'h00);
    wait_idle();
    check("hold_addr",    32'(g_dut[0].addr),    32'd5);
    check("hold_data_in", 32'(g_dut[0].data_in), 32'hA5);

    // Block the FSM in RESP so four writes fill the FIFO, then release them as a burst.
    rsp_ready = 1'b0;
    send(1'b0, 5'd2, 8'h00);
    send(1'b1, 5'd0,  8'h10);
    send(1'b1, 5'd8,  8'h18);
    send(1'b1, 5'd16, 8'h20);
    send(1'b1, 5'd24, 8'h28);
    check("full_req_ready", 32'(g_dut[0].req_ready), 32'd0);
    check("full_busy",      32'(g_dut[0].busy),      32'd1);
    wait_rsp0();
    rsp_ready = 1'b1;
    run = 0;
    while (!g_dut[0].wr_en && run < 20) begin
      @(negedge clk);
      run++;
    end
    run = 0;
    while (g_dut[0].wr_en && run < 10) begin
      run++;
      @(negedge clk);
    end
    check("wr_burst_len", 32'(run), 32'd4);
    wait_idle();

    // Response back-pressure: data stable and no strobes while rsp_ready is low.
    rsp_ready = 1'b0;
    send(1'b0, 5'd3, 8'h00);
    send(1'b1, 5'd9, 8'h3C);
    wait_rsp0();
    repeat (5) begin
      check("bp_rsp_valid", 32'(g_dut[0].rsp_valid), 32'd1);
      check("bp_rsp_rdata", 32'(g_dut[0].rsp_rdata), 32'(init_val(3)));
      check("bp_rsp_addr",  32'(g_dut[0].rsp_addr),  32'd3);
      check("bp_no_strobe", 32'(g_dut[0].rd_en | g_dut[0].wr_en), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    wait_idle();

    // Top address read; each instance checks its own RD_LAT+1 response latency.
    send(1'b0, 5'd31, 8'h00);
    wait_idle();

    // Reset while the first read sits in WAIT with two more queued.
    send(1'b0, 5'd7,  8'h00);
    send(1'b0, 5'd8,  8'h00);
    send(1'b0, 5'd10, 8'h00);
    check("pre_rst_busy", 32'(g_dut[0].busy), 32'd1);
    rst = 1'b1;
    strobe_q.delete();
    rsp_q.delete();
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
    #1;
    check("arst_rsp_valid", 32'(g_dut[0].rsp_valid), 32'd0);
    check("arst_rd_en",     32'(g_dut[0].rd_en),     32'd0);
    @(negedge clk);
    check("mrst_busy",      32'(g_dut[0].busy | g_dut[1].busy | g_dut[2].busy), 32'd0);
    check("mrst_req_ready", 32'(g_dut[0].req_ready & g_dut[2].req_ready), 32'd1);
    check("mrst_rsp_valid", 32'(g_dut[0].rsp_valid | g_dut[2].rsp_valid), 32'd0);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("post_rst_quiet", 32'(g_dut[0].rd_en | g_dut[0].wr_en | g_dut[0].rsp_valid |
                                  g_dut[2].rd_en | g_dut[2].wr_en | g_dut[2].rsp_valid), 32'd0);
    end

`ifdef CACHE_DRV_STATS_EN
    send(1'b1, 5'd1, 8'h61);
    send(1'b1, 5'd2, 8'h62);
    send(1'b1, 5'd4, 8'h64);
    send(1'b0, 5'd1, 8'h00);
    send(1'b0, 5'd2, 8'h00);
    wait_idle();
    check("stats_wr_cnt", 32'(g_dut[0].wr_cnt), 32'd3);
    check("stats_rd_cnt", 32'(g_dut[0].rd_cnt), 32'd2);
`endif

    // Mixed random traffic through the scoreboard.
    for (int k = 0; k < 16; k++)
      send(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
    wait_idle();

    check("sb_drained", 32'(strobe_q.size() + rsp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_mem_driver.md
# cache_mem_driver

Initiator for the cache-memory port: accepts read/write requests from upstream logic over a valid/ready handshake and buffers them in a small FIFO. Issues each request to the cache as a single-cycle `rd_en`/`wr_en` pulse and returns read data over a valid/ready response channel. Sits between a client (CPU model, test sequencer) and the cache-memory block, and guarantees the cache never sees simultaneous read and write.

## Interface
- `ADDR_W`, 5: address width (32 locations)
- `DATA_W`, 8: data width
- `Q_DEPTH`, 4: request FIFO depth, power of two, ≥2
- `RD_LAT`, 1: cycles from the `rd_en` sampling edge to the edge at which `data_out` is captured, 1..3

- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  upstream request present
- `req_ready`  out  1  request FIFO not full
- `req_wr`  in  1  1 = write, 0 = read
- `req_addr`  in  ADDR_W  request address
- `req_wdata`  in  DATA_W  write data (ignored for reads)
- `rsp_valid`  out  1  read response present
- `rsp_ready`  in  1  client accepts response
- `rsp_addr`  out  ADDR_W  address of the returned read
- `rsp_rdata`  out  DATA_W  read data
- `rd_en`  out  1  to cache: read strobe
- `wr_en`  out  1  to cache: write strobe
- `addr`  out  ADDR_W  to cache: address
- `data_in`  out  DATA_W  to cache: write data
- `data_out`  in  DATA_W  from cache: read data
- `busy`  out  1  FIFO non-empty or FSM not IDLE

## Operation
- Request accepted on an edge where `req_valid && req_ready`; pushed into the FIFO as {wr, addr, wdata}.
- `req_ready` = FIFO not full; no pass-through when full, even if a pop occurs in the same cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: FIFO non-empty → pop head, go to ISSUE.
  - ISSUE: drive one-cycle `wr_en` or `rd_en` with `addr`/`data_in`. Write → IDLE, or straight back to ISSUE with the next head if the FIFO is non-empty. Read → WAIT, with the latency counter loaded to RD_LAT.
  - WAIT: decrement the counter; at 0, capture `data_out` into `rsp_rdata` and go to RESP.
  - RESP: `rsp_valid`=1; `rsp_addr`/`rsp_rdata` held stable until `rsp_ready`; then IDLE.
- `rd_en` and `wr_en` are never high together; both are 0 outside ISSUE.
- `addr`/`data_in` hold their last issued value between strobes.
- Responses return in request order; only one read is outstanding.
- FIFO pointers are log2(Q_DEPTH)+1 bits and wrap modulo 2·Q_DEPTH; full/empty are decided by the MSB compare.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_addr`=0, `rsp_rdata`=0, `rd_en`=0, `wr_en`=0, `addr`=0, `data_in`=0, `busy`=0. FIFO is empty and the FSM is in IDLE.
- Request accepted at edge E → earliest strobe is in the cycle after E+1 (IDLE pop cycle, then ISSUE).
- Write throughput: one `wr_en` cycle per clock while queued writes are back-to-back.
- Read with `rd_en` high in cycle T:
  - `data_out` is captured at the edge ending cycle T+RD_LAT.
  - `rsp_valid` is high from cycle T+RD_LAT+1.
- `rst` asserted mid-operation: any in-flight read is dropped with no response, queued requests are discarded, and outputs return to reset values immediately.
- Push while FIFO is empty and FSM is IDLE: the pop occurs on the following edge; there is no same-cycle bypass.

## Configuration
- `CACHE_DRV_STATS_EN` defined: adds outputs `rd_cnt` and `wr_cnt`, 16-bit each.
  - Each counts issued `rd_en`/`wr_en` strobes and saturates at 16'hFFFF.
  - Both reset to 0.
- Undefined: the counters and their ports are absent; all other behaviour is identical.

## Structure
- Package `cache_drv_pkg`: `req_t` struct {wr, addr, wdata}, the FSM state enum, and `ADDR_W`/`DATA_W` defaults.
- Sub-module `cache_req_fifo`: parameterized synchronous FIFO of `req_t` with push/pop/full/empty.

## Test plan
- After reset, queue write addr 5 data 8'hA5, then read addr 5 → one `wr_en` pulse with addr 5/data_in A5, then `rd_en` addr 5; `rsp_rdata`=8'hA5, `rsp_addr`=5 at cycle T+RD_LAT+1.
- Queue 4 writes back-to-back to addrs 0,8,16,24 → `req_ready` drops after the 4th push; four consecutive `wr_en` cycles; `rd_en`/`wr_en` never both high.
- Read addr 3 with `rsp_ready` held 0 for 5 cycles → `rsp_valid` stays high with data stable; no new strobe is issued until the response is accepted.
- Sweep RD_LAT=1,2,3 with a read of addr 31 → `rsp_valid` first rises exactly RD_LAT+1 cycles after the `rd_en` cycle.
- Assert `rst` during WAIT with 2 requests queued → no `rsp_valid`, `busy`=0 and `req_ready`=1 the next cycle, and no strobes after reset deasserts.
- With `CACHE_DRV_STATS_EN` defined, issue 3 writes and 2 reads → `wr_cnt`=3, `rd_cnt`=2.
